// File: rtl/uart_pkg.sv
// Shared types for the count-to-UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick pulses for one cycle every CLKS_PER_BIT cycles.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_count_tx.sv
// 8N1/8N2 UART transmitter with a one-byte holding register ahead of the shifter.
module uart_count_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_count_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_count_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_W - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    uart_tx_state_t         state_q, state_d;
    logic [UART_DATA_W-1:0] hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   restart;
    logic                   tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    assign in_ready = ~hold_full_q;
    assign busy     = (state_q != IDLE) | hold_full_q;
    assign tx       = tx_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        restart     = 1'b0;

        // Accept and drain are exclusive: accept needs hold empty, drain needs it full.
        if (in_valid && in_ready) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    restart     = 1'b1;
                    tx_d        = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q != LAST_STOP_IDX) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (hold_full_q) begin
                        // Back-to-back frame: next start bit follows the last stop bit directly.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        restart     = 1'b1;
                        tx_d        = 1'b0;
                        state_d     = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
        end
    end

endmodule
